// File: rtl/pcs_tx_frame_arb.sv
// Two-source round-robin frame arbiter for the 66b PCS TX block path.
// Locks a grant per frame, fills gaps with IDLE and drains runaway frames.
module pcs_tx_frame_arb #(
  parameter int MAX_BLKS  = 128,
  parameter int CNT_W     = 8,
  parameter bit IDLE_FILL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [65:0] s0_dat,
  input  logic        s0_vld,
  input  logic        s0_last,
  output logic        s0_rdy,
  input  logic [65:0] s1_dat,
  input  logic        s1_vld,
  input  logic        s1_last,
  output logic        s1_rdy,
  output logic [65:0] m_dat,
  output logic        m_vld,
  input  logic        m_rdy,
  output logic        busy,
  output logic        grant,
  output logic        err_tmo
);

  localparam logic [65:0] IDLE_BLK =
    {2'b10, 64'h000000000000001e};
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MAX_BLKS);

  typedef enum logic [1:0] {
    ARB,
    SEND,
    DRAIN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] blk_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             slot;
  logic             sel_vld;
  logic             sel_last;
  logic             sel_rdy;
  logic [65:0]      sel_dat;
  logic             acc;
  logic             any_vld;
  logic             nxt_grant;

  assign slot     = !m_vld || m_rdy;
  assign sel_vld  = grant ? s1_vld  : s0_vld;
  assign sel_last = grant ? s1_last : s0_last;
  assign sel_dat  = grant ? s1_dat  : s0_dat;
  assign any_vld  = s0_vld || s1_vld;
  assign cnt_nxt  = blk_cnt + CNT_ONE;
  assign busy     = (state != ARB);

  // Tie goes to the source not served last time.
  assign nxt_grant = (s0_vld && s1_vld) ? ~grant : s1_vld;

  always_comb begin
    sel_rdy = 1'b0;
    unique case (state)
      SEND:    sel_rdy = slot;
      DRAIN:   sel_rdy = 1'b1;
      default: sel_rdy = 1'b0;
    endcase
  end

  assign s0_rdy = sel_rdy && !grant;
  assign s1_rdy = sel_rdy && grant;
  assign acc    = sel_vld && sel_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB;
      m_dat   <= '0;
      m_vld   <= 1'b0;
      grant   <= 1'b1;
      blk_cnt <= '0;
      err_tmo <= 1'b0;
    end else begin
      err_tmo <= 1'b0;
      unique case (state)
        SEND: begin
          if (acc) begin
            m_dat   <= sel_dat;
            m_vld   <= 1'b1;
            blk_cnt <= cnt_nxt;
            if (sel_last) begin
              state <= ARB;
            end else if (cnt_nxt == CNT_MAX) begin
              err_tmo <= 1'b1;
              state   <= DRAIN;
            end
          end else if (slot) begin
            m_vld <= 1'b0;
          end
        end
        DRAIN: begin
          if (slot) begin
            m_dat <= IDLE_BLK;
            m_vld <= IDLE_FILL;
          end
          if (acc && sel_last) begin
            state <= ARB;
          end
        end
        default: begin
          if (slot) begin
            m_dat <= IDLE_BLK;
            m_vld <= IDLE_FILL;
          end
          if (en && any_vld) begin
            grant   <= nxt_grant;
            blk_cnt <= '0;
            state   <= SEND;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcs_tx_frame_arb.sv
// Directed bench for pcs_tx_frame_arb: per-cycle vector table
// plus hand-written watchdog and mid-frame reset sequences.
module tb_pcs_tx_frame_arb;

  localparam logic [65:0] IDLE_BLK =
    {2'b10, 64'h000000000000001e};
  localparam logic [2:0] IDL = 3'd0;
  localparam logic [2:0] S0  = 3'd1;
  localparam logic [2:0] S1  = 3'd2;
  localparam logic [2:0] ZR  = 3'd3;
  localparam logic [2:0] DC  = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [65:0] s0_dat;
  logic        s0_vld;
  logic        s0_last;
  logic        s0_rdy;
  logic [65:0] s1_dat;
  logic        s1_vld;
  logic        s1_last;
  logic        s1_rdy;
  logic [65:0] m_dat;
  logic        m_vld;
  logic        m_rdy;
  logic        busy;
  logic        grant;
  logic        err_tmo;

  pcs_tx_frame_arb #(
    .MAX_BLKS (128),
    .CNT_W    (8),
    .IDLE_FILL(1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .s0_dat (s0_dat),
    .s0_vld (s0_vld),
    .s0_last(s0_last),
    .s0_rdy (s0_rdy),
    .s1_dat (s1_dat),
    .s1_vld (s1_vld),
    .s1_last(s1_last),
    .s1_rdy (s1_rdy),
    .m_dat  (m_dat),
    .m_vld  (m_vld),
    .m_rdy  (m_rdy),
    .busy   (busy),
    .grant  (grant),
    .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en;
    logic       s0v, s0l;
    logic [7:0] s0t;
    logic       s1v, s1l;
    logic [7:0] s1t;
    logic       mrdy;
    logic       e0r, e1r, evld;
    logic [2:0] esrc;
    logic [7:0] etag;
    logic       ebusy, egnt, etmo;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   pass  = 0;

  function automatic logic [65:0] blk(
    input logic src1, input logic [7:0] tag);
    return {2'b01, src1 ? 8'h51 : 8'h50, 48'h0, tag};
  endfunction

  function automatic logic [65:0] exp_dat(
    input logic [2:0] src, input logic [7:0] tag);
    case (src)
      IDL:     return IDLE_BLK;
      S0:      return blk(1'b0, tag);
      S1:      return blk(1'b1, tag);
      default: return '0;
    endcase
  endfunction

  function automatic void add(
    input logic r, e, a0v, a0l, input logic [7:0] a0t,
    input logic a1v, a1l, input logic [7:0] a1t,
    input logic mr, x0r, x1r, xv,
    input logic [2:0] xs, input logic [7:0] xt,
    input logic xb, xg, xe);
    vec_t v;
    v.rst = r;    v.en = e;
    v.s0v = a0v;  v.s0l = a0l;  v.s0t = a0t;
    v.s1v = a1v;  v.s1l = a1l;  v.s1t = a1t;
    v.mrdy = mr;
    v.e0r = x0r;  v.e1r = x1r;  v.evld = xv;
    v.esrc = xs;  v.etag = xt;
    v.ebusy = xb; v.egnt = xg;  v.etmo = xe;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [65:0] act,
                     input logic [65:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s @%0d: got %h want %h",
                  nm, idx, act, exp);
  endtask

  task automatic idle_in();
    s0_vld = 0; s0_last = 0; s0_dat = '0;
    s1_vld = 0; s1_last = 0; s1_dat = '0;
  endtask

  initial begin
    int idx, fwd, tmo, bad, leak, cyc;
    logic acc;

    rst = 1; en = 1; m_rdy = 1;
    idle_in();
    repeat (2) @(posedge clk);

    // reset and idle fill
    add(1,1, 0,0,0, 0,0,0, 1, 0,0, 0,ZR,0, 0,1,0);
    add(0,1, 0,0,0, 0,0,0, 1, 0,0, 1,IDL,0, 0,1,0);
    add(0,1, 0,0,0, 0,0,0, 1, 0,0, 1,IDL,0, 0,1,0);
    // s0 ten-block frame
    add(0,1, 1,0,0, 0,0,0, 1, 0,0, 1,IDL,0, 1,0,0);
    for (int k = 0; k < 10; k++)
      add(0,1, 1,(k==9),8'(k), 0,0,0, 1,
          1,0, 1,S0,8'(k), (k!=9),0,0);
    add(0,1, 0,0,0, 0,0,0, 1, 0,0, 1,IDL,0, 0,0,0);
    // s1 frame with m_rdy toggling
    add(0,1, 0,0,0, 1,0,8'h20, 1, 0,0, 1,IDL,0,   1,1,0);
    add(0,1, 0,0,0, 1,0,8'h20, 1, 0,1, 1,S1,8'h20, 1,1,0);
    add(0,1, 0,0,0, 1,0,8'h21, 0, 0,0, 1,S1,8'h20, 1,1,0);
    add(0,1, 0,0,0, 1,0,8'h21, 1, 0,1, 1,S1,8'h21, 1,1,0);
    add(0,1, 0,0,0, 1,0,8'h22, 0, 0,0, 1,S1,8'h21, 1,1,0);
    add(0,1, 0,0,0, 1,0,8'h22, 1, 0,1, 1,S1,8'h22, 1,1,0);
    // s1 underrun for three cycles
    for (int k = 0; k < 3; k++)
      add(0,1, 0,0,0, 0,0,0, 1, 0,1, 0,DC,0, 1,1,0);
    add(0,1, 0,0,0, 1,1,8'h23, 1, 0,1, 1,S1,8'h23, 0,1,0);
    add(0,1, 0,0,0, 0,0,0, 1, 0,0, 1,IDL,0, 0,1,0);
    // reset, then both sources with 3-block frames
    add(1,1, 0,0,0, 0,0,0, 1, 0,0, 0,ZR,0, 0,1,0);
    add(0,1, 1,0,8'h30, 1,0,8'h40, 1, 0,0, 1,IDL,0,   1,0,0);
    add(0,1, 1,0,8'h30, 1,0,8'h40, 1, 1,0, 1,S0,8'h30, 1,0,0);
    add(0,1, 1,0,8'h31, 1,0,8'h40, 1, 1,0, 1,S0,8'h31, 1,0,0);
    add(0,1, 1,1,8'h32, 1,0,8'h40, 1, 1,0, 1,S0,8'h32, 0,0,0);
    add(0,1, 1,0,8'h33, 1,0,8'h40, 1, 0,0, 1,IDL,0,   1,1,0);
    add(0,1, 1,0,8'h33, 1,0,8'h40, 1, 0,1, 1,S1,8'h40, 1,1,0);
    add(0,1, 1,0,8'h33, 1,0,8'h41, 1, 0,1, 1,S1,8'h41, 1,1,0);
    add(0,1, 1,0,8'h33, 1,1,8'h42, 1, 0,1, 1,S1,8'h42, 0,1,0);
    add(0,1, 1,0,8'h33, 1,0,8'h43, 1, 0,0, 1,IDL,0,   1,0,0);
    add(0,1, 1,0,8'h33, 1,0,8'h43, 1, 1,0, 1,S0,8'h33, 1,0,0);
    add(0,1, 1,0,8'h34, 1,0,8'h43, 1, 1,0, 1,S0,8'h34, 1,0,0);
    add(0,1, 1,1,8'h35, 1,0,8'h43, 1, 1,0, 1,S0,8'h35, 0,0,0);
    add(0,1, 0,0,0, 0,0,0, 1, 0,0, 1,IDL,0, 0,0,0);
    // en gating and a single-block frame
    add(0,0, 1,1,8'h50, 0,0,0, 1, 0,0, 1,IDL,0,   0,0,0);
    add(0,1, 1,1,8'h50, 0,0,0, 1, 0,0, 1,IDL,0,   1,0,0);
    add(0,1, 1,1,8'h50, 0,0,0, 1, 1,0, 1,S0,8'h50, 0,0,0);
    add(0,1, 0,0,0, 0,0,0, 1, 0,0, 1,IDL,0, 0,0,0);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst     = tbl[i].rst;
      en      = tbl[i].en;
      s0_vld  = tbl[i].s0v;
      s0_last = tbl[i].s0l;
      s0_dat  = blk(1'b0, tbl[i].s0t);
      s1_vld  = tbl[i].s1v;
      s1_last = tbl[i].s1l;
      s1_dat  = blk(1'b1, tbl[i].s1t);
      m_rdy   = tbl[i].mrdy;
      #1;
      chk("s0_rdy", i, 66'(s0_rdy), 66'(tbl[i].e0r));
      chk("s1_rdy", i, 66'(s1_rdy), 66'(tbl[i].e1r));
      @(posedge clk);
      #1;
      chk("m_vld", i, 66'(m_vld), 66'(tbl[i].evld));
      if (tbl[i].esrc != DC)
        chk("m_dat", i, m_dat,
            exp_dat(tbl[i].esrc, tbl[i].etag));
      chk("busy", i, 66'(busy), 66'(tbl[i].ebusy));
      chk("grant", i, 66'(grant), 66'(tbl[i].egnt));
      chk("err_tmo", i, 66'(err_tmo), 66'(tbl[i].etmo));
    end

    // runaway 130-block frame from s0
    idx = 0; fwd = 0; tmo = 0; bad = 0; leak = 0; cyc = 0;
    rst = 0; en = 1; m_rdy = 1;
    while (idx < 130 && cyc < 400) begin
      @(negedge clk);
      idle_in();
      s0_vld  = 1;
      s0_dat  = blk(1'b0, 8'(idx));
      s0_last = (idx == 129);
      #1;
      acc = s0_rdy;
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (m_vld && m_dat[65:56] == {2'b01, 8'h50}) begin
        if (m_dat[7:0] != 8'(fwd)) bad++;
        fwd++;
      end
      if (err_tmo) tmo++;
      else if (tmo > 0 && m_dat !== IDLE_BLK) leak++;
      cyc++;
    end
    @(negedge clk);
    idle_in();
    @(posedge clk);
    #1;
    chk("wd_accepted", 0, 66'(idx), 66'd130);
    chk("wd_forwarded", 0, 66'(fwd), 66'd128);
    chk("wd_order_errs", 0, 66'(bad), 66'd0);
    chk("wd_tmo_pulses", 0, 66'(tmo), 66'd1);
    chk("wd_drain_leak", 0, 66'(leak), 66'd0);
    chk("wd_busy", 0, 66'(busy), 66'd0);
    chk("wd_m_dat", 0, m_dat, IDLE_BLK);

    // reset in the middle of an s1 frame
    repeat (3) begin
      @(negedge clk);
      s1_vld  = 1;
      s1_last = 0;
      s1_dat  = blk(1'b1, 8'h60);
      @(posedge clk);
    end
    #1;
    chk("mr_pre_busy", 0, 66'(busy), 66'd1);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("mr_m_vld", 0, 66'(m_vld), 66'd0);
    chk("mr_m_dat", 0, m_dat, 66'd0);
    chk("mr_busy", 0, 66'(busy), 66'd0);
    chk("mr_grant", 0, 66'(grant), 66'd1);
    chk("mr_err", 0, 66'(err_tmo), 66'd0);
    chk("mr_s1_rdy", 0, 66'(s1_rdy), 66'd0);
    @(negedge clk);
    rst = 0;
    idle_in();
    @(posedge clk);
    #1;
    chk("mr_post_vld", 0, 66'(m_vld), 66'd1);
    chk("mr_post_dat", 0, m_dat, IDLE_BLK);
    chk("mr_post_busy", 0, 66'(busy), 66'd0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
